muldiv_ctrl: RTL and testbench

Sequencer for the MIPS HI/LO multiply/divide resource. It decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the instruction word and runs a 32-iteration shift-add multiply or restoring divide. It owns the HI and LO registers. It stalls the issuing stage whenever a HI/LO instruction arrives while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_iter.sv | 77 +++++++
 rtl/muldiv_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the MIPS HI/LO multiply/divide
//               sequencer: opcode/func encodings, FSM states, datapath
//               step mode and a helper that takes operand magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    localparam logic [4:0] ITER_LAST  = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    // Magnitude of a 32-bit operand; 8000_0000 maps onto itself, which is
    // the correct unsigned magnitude 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : One-bit-per-cycle multiply/divide datapath. Holds the 64-bit
//               accumulator and the 32-bit multiplicand/divisor register.
//               MODE_MUL: shift-add, accumulator starts as {0, multiplier}.
//               MODE_DIV: restoring divide, accumulator starts as
//                         {0, dividend}; ends as {remainder, quotient}.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load_i        - load acc_lo_i / opnd_i (acc upper half := 0)
//               step_i        - perform one iteration in mode_i
//               mode_i        - MODE_MUL or MODE_DIV
//               acc_lo_i      - multiplier or dividend magnitude
//               opnd_i        - multiplicand or divisor magnitude
//               acc_o         - current accumulator
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  mode_e       mode_i,
    input  logic [31:0] acc_lo_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;

    logic [32:0] w_sum;
    logic [32:0] w_pr;
    logic        w_ge;
    logic [31:0] w_sub;

    always_comb begin
        // Multiply: carry out of the upper-half add shifts back in at bit 63.
        w_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        // Divide: 33-bit partial remainder = remainder shifted left with the
        // next dividend bit. When it is >= divisor the true difference is
        // below 2^32, so a 32-bit subtract is exact.
        w_pr   = {acc_q[63:32], acc_q[31]};
        w_ge   = (w_pr >= {1'b0, opnd_q});
        w_sub  = w_pr[31:0] - opnd_q;

        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load_i) begin
            acc_d  = {32'd0, acc_lo_i};
            opnd_d = opnd_i;
        end else if (step_i) begin
            if (mode_i == MODE_MUL) begin
                acc_d = acc_q[0] ? {w_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
            end else begin
                acc_d = w_ge ? {w_sub, acc_q[30:0], 1'b1}
                             : {w_pr[31:0], acc_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Sequencer for the MIPS HI/LO multiply/divide resource.
//               Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, runs a
//               32-iteration multiply or divide, applies sign fixup, owns
//               HI/LO and stalls HI/LO instructions while busy.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               IR            - issue-stage instruction word
//               in_valid      - IR / rs_data / rt_data valid
//               rs_data       - dividend / multiplicand / MTxx source
//               rt_data       - divisor / multiplier
//               stall         - hold issue stage (combinational)
//               busy          - operation in flight (registered)
//               result        - HI or LO for an accepted MFHI/MFLO, else 0
//               result_valid  - MFHI/MFLO accepted this cycle
//               hi, lo        - architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    input  logic        in_valid,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    mode_e       mode_q, mode_d;
    logic        neg_q, neg_d;        // quotient/product needs negation
    logic        remneg_q, remneg_d;  // remainder takes negative dividend sign
    logic        div0_q, div0_d;
    logic [31:0] rs_q, rs_d;          // dividend as issued, for divide by zero

    // ---------------- decode ----------------
    logic [5:0]  w_func;
    logic        w_special;
    logic        w_mfhi, w_mthi, w_mflo, w_mtlo;
    logic        w_mult, w_multu, w_div, w_divu;
    logic        w_is_md, w_is_signed, w_is_div, w_is_hilo;
    logic        w_idle, w_accept;
    logic        w_unused_ir;

    assign w_func      = IR[5:0];
    assign w_special   = (IR[31:26] == OP_SPECIAL);
    assign w_unused_ir = ^IR[25:6];

    assign w_mfhi  = w_special && (w_func == FUNC_MFHI);
    assign w_mthi  = w_special && (w_func == FUNC_MTHI);
    assign w_mflo  = w_special && (w_func == FUNC_MFLO);
    assign w_mtlo  = w_special && (w_func == FUNC_MTLO);
    assign w_mult  = w_special && (w_func == FUNC_MULT);
    assign w_multu = w_special && (w_func == FUNC_MULTU);
    assign w_div   = w_special && (w_func == FUNC_DIV);
    assign w_divu  = w_special && (w_func == FUNC_DIVU);

    assign w_is_md     = w_mult | w_multu | w_div | w_divu;
    assign w_is_signed = w_mult | w_div;
    assign w_is_div    = w_div | w_divu;
    assign w_is_hilo   = w_mfhi | w_mthi | w_mflo | w_mtlo | w_is_md;

    assign w_idle   = (state_q == IDLE);
    assign w_accept = in_valid & w_is_hilo & w_idle;

    assign stall        = in_valid & w_is_hilo & ~w_idle;
    assign result_valid = w_accept & (w_mfhi | w_mflo);
    assign result       = !result_valid ? 32'd0 : (w_mfhi ? hi_q : lo_q);

    // ---------------- datapath ----------------
    logic [31:0] w_rs_mag, w_rt_mag;
    logic [63:0] w_acc;
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;

    assign w_rs_mag = mag32(rs_data, w_is_signed);
    assign w_rt_mag = mag32(rt_data, w_is_signed);

    muldiv_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_accept & w_is_md),
        .step_i   (state_q == CALC),
        .mode_i   (mode_q),
        .acc_lo_i (w_is_div ? w_rs_mag : w_rt_mag),
        .opnd_i   (w_is_div ? w_rt_mag : w_rs_mag),
        .acc_o    (w_acc)
    );

    assign w_prod = neg_q    ? (64'd0 - w_acc)        : w_acc;
    assign w_quot = neg_q    ? (32'd0 - w_acc[31:0])  : w_acc[31:0];
    assign w_rem  = remneg_q ? (32'd0 - w_acc[63:32]) : w_acc[63:32];

    // ---------------- FSM / register next-state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mode_d   = mode_q;
        neg_d    = neg_q;
        remneg_d = remneg_q;
        div0_d   = div0_q;
        rs_d     = rs_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_mthi) hi_d = rs_data;
                    if (w_mtlo) lo_d = rs_data;
                    if (w_is_md) begin
                        state_d  = CALC;
                        cnt_d    = '0;
                        mode_d   = w_is_div ? MODE_DIV : MODE_MUL;
                        neg_d    = w_is_signed & (rs_data[31] ^ rt_data[31]);
                        remneg_d = w_div & rs_data[31];
                        div0_d   = w_is_div & (rt_data == 32'd0);
                        rs_d     = rs_data;
                    end
                end
            end
            CALC: begin
                if (cnt_q == ITER_LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (mode_q == MODE_MUL) begin
                    hi_d = w_prod[63:32];
                    lo_d = w_prod[31:0];
                end else if (div0_q) begin
                    hi_d = rs_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = w_rem;
                    lo_d = w_quot;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mode_q   <= MODE_MUL;
            neg_q    <= 1'b0;
            remneg_q <= 1'b0;
            div0_q   <= 1'b0;
            rs_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mode_q   <= mode_d;
            neg_q    <= neg_d;
            remneg_q <= remneg_d;
            div0_q   <= div0_d;
            rs_q     <= rs_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl. A driver issues directed
//               and random instructions and updates an arithmetic reference
//               model of HI/LO on acceptance; expected MFHI/MFLO results are
//               queued and a separate monitor compares them whenever the DUT
//               raises result_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR;
    logic        in_valid;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy, result_valid;
    logic [31:0] result, hi, lo;

    muldiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .IR           (IR),
        .in_valid     (in_valid),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'd0, mid, f};
    endfunction

    function automatic logic [31:0] non_hilo();
        logic [5:0] op;
        logic [5:0] f;
        if ($urandom_range(0, 1) == 0) begin
            op = 6'($urandom_range(1, 63));
            f  = 6'($urandom);
            return {op, 20'($urandom), f};
        end
        case ($urandom_range(0, 3))
            0: f = 6'h20;
            1: f = 6'h21;
            2: f = 6'h2A;
            default: f = 6'h08;
        endcase
        return {6'd0, 20'($urandom), f};
    endfunction

    function automatic bit is_hilo(input logic [31:0] ir);
        return (ir[31:26] == 6'd0) &&
               (ir[5:0] inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Reference model: architectural effect of an accepted instruction.
    task automatic model_accept(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
        int                ia, ib;
        longint            sp;
        longint unsigned   up;
        ia = a;
        ib = b;
        if (!is_hilo(ir)) return;
        case (ir[5:0])
            F_MFHI: exp_q.push_back(m_hi);
            F_MFLO: exp_q.push_back(m_lo);
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            F_MULT: begin
                sp   = longint'(ia) * longint'(ib);
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            F_MULTU: begin
                up   = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            F_DIV: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    m_lo = ia / ib; m_hi = ia % ib;
                end
            end
            default: begin // DIVU
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
        endcase
    endtask

    // Present an instruction from posedge+1 until accepted. Returns the
    // number of stalled cycles and the result outputs in the accept cycle.
    task automatic issue(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic [31:0] res, output logic rv);
        logic st;
        bit   ok;
        IR = ir; rs_data = a; rt_data = b; in_valid = 1'b1;
        stalls = 0; ok = 0; res = '0; rv = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            st = stall;
            if (!is_hilo(ir) && k == 0) chk("nonhilo_stall", {31'd0, st}, 32'd0);
            if (!st) begin
                res = result;
                rv  = result_valid;
                model_accept(ir, a, b);
                ok  = 1;
            end
            @(posedge clk); #1;
            if (ok) break;
            stalls++;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: IR %h never accepted, expected acceptance within 100 cycles", ir);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        IR = non_hilo();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Run a mul/div, read back HI and LO through the scoreboard, then check
    // the debug HI/LO ports against the expected constants.
    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int s; logic [31:0] r; logic v;
        issue(rtype(f), a, b, s, r, v);
        issue(rtype(F_MFHI), 32'd0, 32'd0, s, r, v);
        issue(rtype(F_MFLO), 32'd0, 32'd0, s, r, v);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    // Monitor: every result_valid must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL mon_unexpected: result_valid with result %h, expected no result", result);
                end else begin
                    chk("mon_result", result, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s, busy_cnt, bad_cnt;
        logic [31:0] r;
        logic        v;

        rst = 1'b1; in_valid = 1'b0; IR = '0; rs_data = '0; rt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst = 1'b0;

        // MULTU FFFF_FFFF x 2 with in_valid low afterwards: busy cycles 1..33.
        issue(rtype(F_MULTU), 32'hFFFF_FFFF, 32'd2, s, r, v);
        in_valid = 1'b0;
        IR = rtype(F_MFLO);
        busy_cnt = 0; bad_cnt = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && k <= 33) busy_cnt++;
            if (busy !== 1'b0 && k == 34) bad_cnt++;
            if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) bad_cnt++;
        end
        chk("multu_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("idle_outputs_and_busy_fall", 32'(bad_cnt), 32'd0);
        chk("multu_hi_c34", hi, 32'h0000_0001);
        chk("multu_lo_c34", lo, 32'hFFFF_FFFE);
        @(posedge clk); #1;

        run_md("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_zero", F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_md("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md("div_zero_neg", F_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // Dependent MFLO presented at cycle 1.
        issue(rtype(F_MULTU), 32'd3, 32'd4, s, r, v);
        issue(rtype(F_MFLO), 32'd0, 32'd0, s, r, v);
        chk("dep_mflo_stalls", 32'(s), 32'd33);
        chk("dep_mflo_result", r, 32'h0000_000C);
        chk("dep_mflo_valid", {31'd0, v}, 32'd1);

        issue(rtype(F_MTHI), 32'h1234_5678, 32'd0, s, r, v);
        chk("mthi_hi", hi, 32'h1234_5678);
        issue(rtype(F_MTLO), 32'hCAFE_F00D, 32'd0, s, r, v);
        chk("mtlo_lo", lo, 32'hCAFE_F00D);

        // Back-to-back MULT: second one stalls while the first is in flight.
        issue(rtype(F_MULT), 32'd6, 32'd7, s, r, v);
        issue(rtype(F_MULT), 32'hFFFF_FFFE, 32'hFFFF_FFFE, s, r, v);
        chk("b2b_mult_stalls", 32'(s), 32'd33);
        issue(rtype(F_MFLO), 32'd0, 32'd0, s, r, v);
        chk("b2b_mult_lo", lo, 32'd4);

        // MTHI while busy stalls until the FIX write has landed.
        issue(rtype(F_MULTU), 32'd10, 32'd10, s, r, v);
        issue(rtype(F_MTHI), 32'hAAAA_5555, 32'd0, s, r, v);
        chk("stalled_mthi_hi", hi, 32'hAAAA_5555);
        chk("stalled_mthi_lo", lo, 32'd100);

        // Reset in the middle of a DIVU.
        issue(rtype(F_DIVU), 32'd100, 32'd7, s, r, v);
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        issue(rtype(F_MFLO), 32'd0, 32'd0, s, r, v);
        chk("rst_mid_idle_nostall", 32'(s), 32'd0);
        run_md("post_rst_multu", F_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        // Random mix checked through the scoreboard.
        for (int n = 0; n < 50; n++) begin
            logic [31:0] a, b;
            a = pick_operand();
            b = pick_operand();
            case ($urandom_range(0, 8))
                0: issue(rtype(F_MULT), a, b, s, r, v);
                1: issue(rtype(F_MULTU), a, b, s, r, v);
                2: issue(rtype(F_DIV), a, b, s, r, v);
                3: issue(rtype(F_DIVU), a, b, s, r, v);
                4: issue(rtype(F_MTHI), a, b, s, r, v);
                5: issue(rtype(F_MTLO), a, b, s, r, v);
                6: issue(rtype(F_MFHI), a, b, s, r, v);
                7: issue(rtype(F_MFLO), a, b, s, r, v);
                default: issue(non_hilo(), a, b, s, r, v);
            endcase
            if ($urandom_range(0, 2) == 0) issue(non_hilo(), a, b, s, r, v);
            issue(rtype(F_MFHI), 32'd0, 32'd0, s, r, v);
            issue(rtype(F_MFLO), 32'd0, 32'd0, s, r, v);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
